hdmi_video_gen: RTL

Video timing and pixel source for the HDMI pipeline. It generates the hdmi_de / hdmi_hs / hdmi_vs / RGB stream that the downstream HDMI overlay stages consume. Pixel data comes from an external fetch interface with fixed one-cycle read latency, or from a built-in colour-bar generator when compiled in. Raster counters run from one pixel clock with a clock enable.

---
 rtl/hdmi_video_pkg.sv | 38 +++
 rtl/hdmi_video_gen_if.sv | 32 +++
 rtl/hdmi_raster_counter.sv | 74 +++++++
 rtl/hdmi_video_gen.sv | 130 +++++++++++++
 4 files changed

// File: rtl/hdmi_video_pkg.sv
// Shared types and constants for the HDMI video generator: timing record,
// 24-bit colour type, colour-bar palette and coordinate width.
package hdmi_video_pkg;

   localparam int COORD_W = 10;

   typedef struct packed {
      logic [COORD_W-1:0] active;
      logic [COORD_W-1:0] fp;
      logic [COORD_W-1:0] sync;
      logic [COORD_W-1:0] bp;
   } timing_t;

   typedef logic [23:0] rgb_t;

   localparam rgb_t BAR_WHITE   = 24'hFFFFFF;
   localparam rgb_t BAR_YELLOW  = 24'hFFFF00;
   localparam rgb_t BAR_CYAN    = 24'h00FFFF;
   localparam rgb_t BAR_GREEN   = 24'h00FF00;
   localparam rgb_t BAR_MAGENTA = 24'hFF00FF;
   localparam rgb_t BAR_RED     = 24'hFF0000;
   localparam rgb_t BAR_BLUE    = 24'h0000FF;
   localparam rgb_t BAR_BLACK   = 24'h000000;

   function automatic rgb_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return BAR_WHITE;
         3'd1:    return BAR_YELLOW;
         3'd2:    return BAR_CYAN;
         3'd3:    return BAR_GREEN;
         3'd4:    return BAR_MAGENTA;
         3'd5:    return BAR_RED;
         3'd6:    return BAR_BLUE;
         default: return BAR_BLACK;
      endcase
   endfunction

endpackage

// File: rtl/hdmi_video_gen_if.sv
// Pixel-fetch and video-output bundle between the generator (master) and its
// fetch source / HDMI sink (slave). Fetch has no valid/ready: data is due one ce-cycle after pix_req.
interface hdmi_video_gen_if;
   import hdmi_video_pkg::*;

   logic               pix_req;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic [7:0]         pix_r;
   logic [7:0]         pix_g;
   logic [7:0]         pix_b;
   logic               hdmi_de;
   logic               hdmi_hs;
   logic               hdmi_vs;
   logic [7:0]         hdmi_r;
   logic [7:0]         hdmi_g;
   logic [7:0]         hdmi_b;
   logic               frame_start;

   modport master (
      output pix_req, pix_x, pix_y,
      input  pix_r, pix_g, pix_b,
      output hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b, frame_start
   );

   modport slave (
      input  pix_req, pix_x, pix_y,
      output pix_r, pix_g, pix_b,
      input  hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b, frame_start
   );

endinterface

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster counters with wrap logic and region decode.
// Decode outputs are combinational from the counters; sync outputs are active-high here.
module hdmi_raster_counter
   import hdmi_video_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int H_FP   = 4,
   parameter int H_SYNC = 8,
   parameter int H_BP   = 4,
   parameter int V_FP   = 2,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   output logic [COORD_W-1:0] h_cnt,
   output logic [COORD_W-1:0] v_cnt,
   output logic               active,
   output logic               hs,
   output logic               vs
);

   localparam timing_t H_T = '{active: COORD_W'(IMG_W), fp: COORD_W'(H_FP),
                               sync: COORD_W'(H_SYNC), bp: COORD_W'(H_BP)};
   localparam timing_t V_T = '{active: COORD_W'(IMG_H), fp: COORD_W'(V_FP),
                               sync: COORD_W'(V_SYNC), bp: COORD_W'(V_BP)};

   localparam int H_TOTAL = int'(H_T.active) + int'(H_T.fp) + int'(H_T.sync) + int'(H_T.bp);
   localparam int V_TOTAL = int'(V_T.active) + int'(V_T.fp) + int'(V_T.sync) + int'(V_T.bp);

   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] HS_FIRST = H_T.active + H_T.fp;
   localparam logic [COORD_W-1:0] HS_LAST  = H_T.active + H_T.fp + H_T.sync - COORD_W'(1);
   localparam logic [COORD_W-1:0] VS_FIRST = V_T.active + V_T.fp;
   localparam logic [COORD_W-1:0] VS_LAST  = V_T.active + V_T.fp + V_T.sync - COORD_W'(1);

   logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
   logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
   logic               h_end;

   assign h_end = (h_cnt_q == H_LAST);

   // On the last pixel of the frame both counters wrap on the same edge.
   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (ce) begin
         h_cnt_d = h_end ? '0 : h_cnt_q + COORD_W'(1);
         if (h_end) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + COORD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign h_cnt  = h_cnt_q;
   assign v_cnt  = v_cnt_q;
   assign active = (h_cnt_q < H_T.active) && (v_cnt_q < V_T.active);
   assign hs     = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
   assign vs     = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);

endmodule

// File: rtl/hdmi_video_gen.sv
// Video timing and pixel source: raster counter, fetch-request stage and output stage.
// Define HDMI_VIDEO_GEN_BARS_EN to replace the external pixel source with colour bars.
module hdmi_video_gen
   import hdmi_video_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int H_FP   = 4,
   parameter int H_SYNC = 8,
   parameter int H_BP   = 4,
   parameter int V_FP   = 2,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 2,
   parameter bit HS_POL = 1'b1,
   parameter bit VS_POL = 1'b1
) (
   input  logic             hdmi_clk,
   input  logic             rst,
   input  logic             ce,
   hdmi_video_gen_if.master vid
);

   logic [COORD_W-1:0] h_cnt, v_cnt;
   logic               active, hs_raw, vs_raw;

   hdmi_raster_counter #(
      .IMG_W(IMG_W), .IMG_H(IMG_H),
      .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_raster (
      .clk    (hdmi_clk),
      .rst    (rst),
      .ce     (ce),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .active (active),
      .hs     (hs_raw),
      .vs     (vs_raw)
   );

   // Stage 1: fetch request; its pix_req also serves as the stage-1 de.
   logic               pix_req_q, pix_req_d;
   logic [COORD_W-1:0] pix_x_q, pix_x_d;
   logic [COORD_W-1:0] pix_y_q, pix_y_d;
   logic               hs1_q, hs1_d;
   logic               vs1_q, vs1_d;

   // Stage 2: video output.
   logic               de2_q, de2_d;
   logic               hs2_q, hs2_d;
   logic               vs2_q, vs2_d;
   logic               fs_q, fs_d;
   rgb_t               rgb_q, rgb_d;
   rgb_t               src_rgb;

`ifdef HDMI_VIDEO_GEN_BARS_EN
   localparam logic [COORD_W-1:0] BAR_W = COORD_W'(IMG_W / 8);
   logic [COORD_W-1:0] bar_idx;
   assign bar_idx = pix_x_q / BAR_W;
   assign src_rgb = bar_colour(bar_idx[2:0]);
`else
   assign src_rgb = {vid.pix_r, vid.pix_g, vid.pix_b};
`endif

   always_comb begin
      pix_req_d = pix_req_q;
      pix_x_d   = pix_x_q;
      pix_y_d   = pix_y_q;
      hs1_d     = hs1_q;
      vs1_d     = vs1_q;
      de2_d     = de2_q;
      hs2_d     = hs2_q;
      vs2_d     = vs2_q;
      fs_d      = fs_q;
      rgb_d     = rgb_q;
      if (ce) begin
         pix_req_d = active;
         hs1_d     = hs_raw ? HS_POL : ~HS_POL;
         vs1_d     = vs_raw ? VS_POL : ~VS_POL;
         // Coordinates freeze outside the active region.
         if (active) begin
            pix_x_d = h_cnt;
            pix_y_d = v_cnt;
         end
         de2_d = pix_req_q;
         hs2_d = hs1_q;
         vs2_d = vs1_q;
         fs_d  = pix_req_q && (pix_x_q == '0) && (pix_y_q == '0);
         rgb_d = pix_req_q ? src_rgb : '0;
      end
   end

   always_ff @(posedge hdmi_clk) begin
      if (rst) begin
         pix_req_q <= 1'b0;
         pix_x_q   <= '0;
         pix_y_q   <= '0;
         hs1_q     <= ~HS_POL;
         vs1_q     <= ~VS_POL;
         de2_q     <= 1'b0;
         hs2_q     <= ~HS_POL;
         vs2_q     <= ~VS_POL;
         fs_q      <= 1'b0;
         rgb_q     <= '0;
      end else begin
         pix_req_q <= pix_req_d;
         pix_x_q   <= pix_x_d;
         pix_y_q   <= pix_y_d;
         hs1_q     <= hs1_d;
         vs1_q     <= vs1_d;
         de2_q     <= de2_d;
         hs2_q     <= hs2_d;
         vs2_q     <= vs2_d;
         fs_q      <= fs_d;
         rgb_q     <= rgb_d;
      end
   end

   assign vid.pix_req     = pix_req_q;
   assign vid.pix_x       = pix_x_q;
   assign vid.pix_y       = pix_y_q;
   assign vid.hdmi_de     = de2_q;
   assign vid.hdmi_hs     = hs2_q;
   assign vid.hdmi_vs     = vs2_q;
   assign vid.hdmi_r      = rgb_q[23:16];
   assign vid.hdmi_g      = rgb_q[15:8];
   assign vid.hdmi_b      = rgb_q[7:0];
   assign vid.frame_start = fs_q;

endmodule
